transmitter_spi: RTL

//  SPI master (transmitter). Upstream partner of the receiver_SPI slave.
//  - Drives SS, SCK and MOSI; samples MISO.
//  - Shifts out one data_in word per start request, LSB first.
//  - Captures the returned word on data_out.
//  - Supports all four CKP/CPH modes.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/transmitter_spi_if.sv | 26 ++
 rtl/spi_sck_gen.sv | 50 +++++
 rtl/transmitter_spi.sv | 135 +++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM states, SPI mode encodings and default sizing.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        FINISH   = 2'd3
    } state_t;

    // Mode word is {CKP, CPH}
    typedef logic [1:0] mode_t;

    localparam mode_t MODE00 = 2'b00;
    localparam mode_t MODE01 = 2'b01;
    localparam mode_t MODE10 = 2'b10;
    localparam mode_t MODE11 = 2'b11;

    localparam int DEFAULT_N_BITS   = 8;
    localparam int DEFAULT_HALF_PER = 2;

    function automatic logic mode_ckp(input mode_t m);
        return m[1];
    endfunction

    function automatic logic mode_cph(input mode_t m);
        return m[0];
    endfunction

endpackage

// File: rtl/transmitter_spi_if.sv
// Host-side control and SPI pin bundle for transmitter_spi.
interface transmitter_spi_if #(
    parameter int N_BITS = spi_pkg::DEFAULT_N_BITS
);
    logic              CKP;
    logic              CPH;
    logic              start;
    logic [N_BITS-1:0] data_in;
    logic              MISO;
    logic              SS;
    logic              SCK;
    logic              MOSI;
    logic [N_BITS-1:0] data_out;
    logic              busy;
    logic              done;

    modport master (
        input  CKP, CPH, start, data_in, MISO,
        output SS, SCK, MOSI, data_out, busy, done
    );

    modport slave (
        output CKP, CPH, start, data_in, MISO,
        input  SS, SCK, MOSI, data_out, busy, done
    );
endinterface

// File: rtl/spi_sck_gen.sv
// Half-period timer for the SPI master: counts HALF_PER clk cycles and toggles the SCK phase.
module spi_sck_gen import spi_pkg::*; #(
    parameter int HALF_PER = DEFAULT_HALF_PER
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic toggle_en,
    output logic tick,
    output logic lead_edge,
    output logic trail_edge,
    output logic phase
);
    localparam int            CW   = $clog2(HALF_PER + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF_PER - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Strobes mark the clk edge on which SCK changes, so the FSM acts on that same edge.
    always_comb begin
        tick       = run && (cnt_q == LAST);
        lead_edge  = tick && toggle_en && !phase_q;
        trail_edge = tick && toggle_en && phase_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        if (!run) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            if (toggle_en) phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/transmitter_spi.sv
// SPI master: shifts one word out LSB first per accepted start, captures MISO, all four CKP/CPH modes.
module transmitter_spi import spi_pkg::*; #(
    parameter int N_BITS   = DEFAULT_N_BITS,
    parameter int HALF_PER = DEFAULT_HALF_PER
) (
    input  logic              clk,
    input  logic              rst,
    transmitter_spi_if.master bus
);
    localparam logic [4:0] LAST_BIT = 5'(N_BITS);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [N_BITS-1:0] tx_sr_q, tx_sr_d;
    logic [N_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [N_BITS-1:0] data_out_q, data_out_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tick, lead_edge, trail_edge, phase;
    logic              gen_run, gen_toggle, cph_q, sample_now;
    logic [N_BITS:0]   rx_cat;
    logic [N_BITS-1:0] tx_shift;

    assign gen_run    = (state_q != IDLE);
    assign gen_toggle = (state_q == TRANSFER);

    spi_sck_gen #(.HALF_PER(HALF_PER)) u_sck_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (gen_run),
        .toggle_en  (gen_toggle),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .phase      (phase)
    );

    assign cph_q      = mode_cph(mode_q);
    assign sample_now = (lead_edge && !cph_q) || (trail_edge && cph_q);
    assign rx_cat     = {bus.MISO, rx_sr_q};
    assign tx_shift   = tx_sr_q >> 1;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        data_out_d = data_out_q;
        bit_cnt_d  = bit_cnt_q;
        ss_d       = ss_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped, not deferred.
                if (bus.start && !done_q) begin
                    state_d   = SETUP;
                    mode_d    = {bus.CKP, bus.CPH};
                    tx_sr_d   = bus.data_in;
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    ss_d      = 1'b0;
                    busy_d    = 1'b1;
                    if (!bus.CPH) mosi_d = bus.data_in[0];
                end
            end
            SETUP: begin
                if (tick) state_d = TRANSFER;
            end
            TRANSFER: begin
                if (sample_now) begin
                    rx_sr_d = rx_cat[N_BITS:1];
                    if (bit_cnt_q != LAST_BIT) bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (lead_edge && cph_q) mosi_d = tx_sr_q[0];
                if (trail_edge) begin
                    tx_sr_d = tx_shift;
                    // After the last bit MOSI keeps its value instead of shifting in a zero.
                    if (!cph_q && bit_cnt_q != LAST_BIT) mosi_d = tx_shift[0];
                    if (bit_cnt_d == LAST_BIT) state_d = FINISH;
                end
            end
            FINISH: begin
                if (tick) begin
                    state_d    = IDLE;
                    data_out_d = rx_sr_q;
                    done_d     = 1'b1;
                    ss_d       = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= MODE00;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            data_out_q <= '0;
            bit_cnt_q  <= '0;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            data_out_q <= data_out_d;
            bit_cnt_q  <= bit_cnt_d;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Idle SCK tracks the live CKP input; once a transfer starts it uses the latched polarity.
    assign bus.SCK      = (state_q == IDLE) ? bus.CKP : (mode_ckp(mode_q) ^ phase);
    assign bus.SS       = ss_q;
    assign bus.MOSI     = mosi_q;
    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
